mem_port_arbiter: RTL and testbench

Two-requester arbiter for the badge's single-port 256x32 instruction/data memory. It shares the one `Mem` port between the core sequencing FSM (port C) and the program loader/debug front end (port L). Grants are round-robin and one transaction at a time, and the fixed memory read latency is hidden behind a req/gnt/ack handshake. It sits between both requesters and the `Mem` instance, and is the only driver of the memory's address, data and write-enable.

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_port_arbiter_if.sv | 18 +
 rtl/mem_port_arbiter_rr_pick2.sv | 27 ++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
// Holds the FSM state encodings, the port index constants and the default
// memory read latency. The default latency must stay equal to the Mem
// latency assumed by the core FSM's fetch / fetch-buffer sequence.
package mem_port_arbiter_pkg;

    typedef logic [1:0] state_t;
    typedef logic       port_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_WAIT   = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    localparam port_t PORT_C = 1'b0;
    localparam port_t PORT_L = 1'b1;

    localparam int DEF_RD_LAT = 2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side handshake bundle for one arbiter port.
// master : the requester (drives req/we/addr/wdata, sees gnt/ack/rdata)
// slave  : the arbiter   (sees req/we/addr/wdata, drives gnt/ack/rdata)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, ack, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, ack, rdata);
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick.
// Ports: req0/req1 - requests of port C / port L
//        last      - port granted most recently
//        valid     - at least one request is pending
//        winner    - selected port (only meaningful when valid)
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic  req0,
    input  logic  req1,
    input  port_t last,
    output logic  valid,
    output port_t winner
);

    always_comb begin
        valid  = req0 | req1;
        winner = PORT_C;
        if (req0 && req1) begin
            // On a tie the port that did not win last time goes next.
            winner = (last == PORT_C) ? PORT_L : PORT_C;
        end else if (req1) begin
            winner = PORT_L;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of the single-port instruction/data memory.
// Ports: clk, rst         - clock, asynchronous active-high reset
//        c, l             - requester handshakes (core FSM, loader/debug)
//        mem_address/mem_data/mem_wren/mem_out - the Mem port
//        busy             - high whenever the FSM is not idle
// One transaction at a time; every output is a register.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int RD_LAT = DEF_RD_LAT
)(
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  c,
    mem_port_arbiter_if.slave  l,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [DATA_W-1:0]  mem_data,
    output logic               mem_wren,
    input  logic [DATA_W-1:0]  mem_out,
    output logic               busy
);

    localparam int CNT_W = 2;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    port_t             owner_reg;
    port_t             last_reg;
    logic              we_reg;
    logic              enter_done;
    logic              c_gnt_reg, l_gnt_reg, c_ack_reg, l_ack_reg;
    logic [DATA_W-1:0] c_rdata_reg, l_rdata_reg;
    logic [ADDR_W-1:0] mem_address_reg;
    logic [DATA_W-1:0] mem_data_reg;
    logic              mem_wren_reg;
    logic              busy_reg;
    logic              pick_valid;
    port_t             pick_winner;

    rr_pick2 u_pick (
        .req0   (c.req),
        .req1   (l.req),
        .last   (last_reg),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    // enter_done marks the edge on which ack is raised and read data captured.
    always_comb begin
        state_next = state_reg;
        enter_done = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (pick_valid) state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (we_reg || RD_LAT == 1) begin
                    state_next = ST_DONE;
                    enter_done = 1'b1;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Counter reaches 0 on this edge.
                if (cnt_reg == 2'd1) begin
                    state_next = ST_DONE;
                    enter_done = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            owner_reg       <= PORT_C;
            last_reg        <= PORT_L;
            we_reg          <= 1'b0;
            c_gnt_reg       <= 1'b0;
            l_gnt_reg       <= 1'b0;
            c_ack_reg       <= 1'b0;
            l_ack_reg       <= 1'b0;
            c_rdata_reg     <= '0;
            l_rdata_reg     <= '0;
            mem_address_reg <= '0;
            mem_data_reg    <= '0;
            mem_wren_reg    <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg    <= state_next;
            busy_reg     <= (state_next != ST_IDLE);
            c_gnt_reg    <= 1'b0;
            l_gnt_reg    <= 1'b0;
            c_ack_reg    <= 1'b0;
            l_ack_reg    <= 1'b0;
            mem_wren_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        // Latch straight into the Mem-facing registers so
                        // the access is presented during the ACCESS cycle.
                        owner_reg <= pick_winner;
                        last_reg  <= pick_winner;
                        if (pick_winner == PORT_L) begin
                            we_reg          <= l.we;
                            mem_address_reg <= l.addr;
                            mem_data_reg    <= l.wdata;
                            mem_wren_reg    <= l.we;
                            l_gnt_reg       <= 1'b1;
                        end else begin
                            we_reg          <= c.we;
                            mem_address_reg <= c.addr;
                            mem_data_reg    <= c.wdata;
                            mem_wren_reg    <= c.we;
                            c_gnt_reg       <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!(we_reg || RD_LAT == 1)) cnt_reg <= CNT_W'(RD_LAT - 1);
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg - 2'd1;
                end
                default: ;
            endcase

            if (enter_done) begin
                if (owner_reg == PORT_L) begin
                    l_ack_reg <= 1'b1;
                    if (!we_reg) l_rdata_reg <= mem_out;
                end else begin
                    c_ack_reg <= 1'b1;
                    if (!we_reg) c_rdata_reg <= mem_out;
                end
            end
        end
    end

    assign c.gnt       = c_gnt_reg;
    assign l.gnt       = l_gnt_reg;
    assign c.ack       = c_ack_reg;
    assign l.ack       = l_ack_reg;
    assign c.rdata     = c_rdata_reg;
    assign l.rdata     = l_rdata_reg;
    assign mem_address = mem_address_reg;
    assign mem_data    = mem_data_reg;
    assign mem_wren    = mem_wren_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Four arbiters with RD_LAT = 1..4 share
// one stimulus set, each with its own memory model; instance 1 (RD_LAT=2) is
// the main subject, all four are compared in the latency sweep.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        c_req, c_we, l_req, l_we;
    logic [7:0]  c_addr, l_addr;
    logic [31:0] c_wdata, l_wdata;

    logic [3:0]  c_gnt_o, l_gnt_o, c_ack_o, l_ack_o, wren_o, busy_o;
    logic [31:0] c_rdata_o [4];
    logic [31:0] l_rdata_o [4];
    logic [31:0] mdata_o   [4];
    logic [7:0]  maddr_o   [4];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) c_if ();
        mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) l_if ();
        logic [7:0]  m_addr;
        logic [31:0] m_data;
        logic [31:0] m_out;
        logic        m_wren;
        logic        m_busy;
        logic [31:0] ram  [256];
        logic [31:0] pipe [4];

        assign c_if.req   = c_req;
        assign c_if.we    = c_we;
        assign c_if.addr  = c_addr;
        assign c_if.wdata = c_wdata;
        assign l_if.req   = l_req;
        assign l_if.we    = l_we;
        assign l_if.addr  = l_addr;
        assign l_if.wdata = l_wdata;

        assign c_gnt_o[gi]   = c_if.gnt;
        assign l_gnt_o[gi]   = l_if.gnt;
        assign c_ack_o[gi]   = c_if.ack;
        assign l_ack_o[gi]   = l_if.ack;
        assign c_rdata_o[gi] = c_if.rdata;
        assign l_rdata_o[gi] = l_if.rdata;
        assign wren_o[gi]    = m_wren;
        assign busy_o[gi]    = m_busy;
        assign maddr_o[gi]   = m_addr;
        assign mdata_o[gi]   = m_data;

        mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(gi + 1)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .c           (c_if),
            .l           (l_if),
            .mem_address (m_addr),
            .mem_data    (m_data),
            .mem_wren    (m_wren),
            .mem_out     (m_out),
            .busy        (m_busy)
        );

        // Memory model: asynchronous array read followed by RD_LAT-1 stages.
        always_ff @(posedge clk) begin
            if (m_wren) ram[m_addr] <= m_data;
            pipe[0] <= ram[m_addr];
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end

        if (gi == 0) begin : g_comb
            assign m_out = ram[m_addr];
        end else begin : g_pipe
            assign m_out = pipe[gi-1];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    int          w;
    int          g_prev;
    int          ack_at [4];
    logic [31:0] l_exp;
    logic        ack_seen;

    initial begin
        // ---------------- reset with random inputs ----------------
        rst = 1'b1;
        c_req = 1'($urandom); c_we = 1'($urandom); c_addr = 8'($urandom); c_wdata = $urandom;
        l_req = 1'($urandom); l_we = 1'($urandom); l_addr = 8'($urandom); l_wdata = $urandom;
        step(); step();
        chk("rst_c_gnt",   32'(c_gnt_o[1]), 32'd0);
        chk("rst_l_gnt",   32'(l_gnt_o[1]), 32'd0);
        chk("rst_c_ack",   32'(c_ack_o[1]), 32'd0);
        chk("rst_l_ack",   32'(l_ack_o[1]), 32'd0);
        chk("rst_c_rdata", c_rdata_o[1], 32'd0);
        chk("rst_l_rdata", l_rdata_o[1], 32'd0);
        chk("rst_maddr",   32'(maddr_o[1]), 32'd0);
        chk("rst_mdata",   mdata_o[1], 32'd0);
        chk("rst_wren",    32'(wren_o[1]), 32'd0);
        chk("rst_busy",    32'(busy_o[1]), 32'd0);
        c_req = 0; l_req = 0; c_we = 0; l_we = 0;
        rst = 1'b0;
        step(); step(); step();
        chk("idle_busy", 32'(busy_o[1]), 32'd0);

        // ---------------- C write 0xDEADBEEF to 0x10 ----------------
        c_req = 1; c_we = 1; c_addr = 8'h10; c_wdata = 32'hDEADBEEF;
        step();
        chk("cw_gnt",   32'(c_gnt_o[1]), 32'd1);
        chk("cw_wren",  32'(wren_o[1]), 32'd1);
        chk("cw_addr",  32'(maddr_o[1]), 32'h10);
        chk("cw_data",  mdata_o[1], 32'hDEADBEEF);
        chk("cw_busy",  32'(busy_o[1]), 32'd1);
        c_req = 0;
        step();
        chk("cw_ack",   32'(c_ack_o[1]), 32'd1);
        chk("cw_wren_off", 32'(wren_o[1]), 32'd0);
        step();
        chk("cw_ack_pulse", 32'(c_ack_o[1]), 32'd0);
        chk("cw_idle", 32'(busy_o[1]), 32'd0);
        $display("txn C write addr 10 data deadbeef");

        // ---------------- C read 0x10 ----------------
        c_req = 1; c_we = 0; c_addr = 8'h10;
        step();
        chk("cr_gnt",  32'(c_gnt_o[1]), 32'd1);
        chk("cr_wren", 32'(wren_o[1]), 32'd0);
        chk("cr_addr", 32'(maddr_o[1]), 32'h10);
        c_req = 0;
        step();
        chk("cr_no_early_ack", 32'(c_ack_o[1]), 32'd0);
        chk("cr_wait_addr", 32'(maddr_o[1]), 32'h10);
        step();
        chk("cr_ack",   32'(c_ack_o[1]), 32'd1);
        chk("cr_rdata", c_rdata_o[1], 32'hDEADBEEF);
        step();
        chk("cr_rdata_held", c_rdata_o[1], 32'hDEADBEEF);
        $display("txn C read addr 10 data %h", c_rdata_o[1]);

        // ---------------- L write 0x12345678 to 0x20 ----------------
        l_req = 1; l_we = 1; l_addr = 8'h20; l_wdata = 32'h12345678;
        step();
        chk("lw_gnt",  {c_gnt_o[1], l_gnt_o[1]}, 32'b01);
        chk("lw_addr", 32'(maddr_o[1]), 32'h20);
        l_req = 0;
        step();
        chk("lw_ack",  {c_ack_o[1], l_ack_o[1]}, 32'b01);
        step();
        $display("txn L write addr 20 data 12345678");

        // ---------------- tie from reset, 8 alternating reads ----------------
        rst = 1'b1;
        step();
        rst = 1'b0;
        c_req = 1; c_we = 0; c_addr = 8'h10;
        l_req = 1; l_we = 0; l_addr = 8'h20;
        l_exp  = 32'd0;
        g_prev = 0;
        for (int n = 0; n < 8; n++) begin
            w = 0;
            while (!(c_gnt_o[1] || l_gnt_o[1]) && w < 12) begin step(); w++; end
            chk("tie_gnt_order", {c_gnt_o[1], l_gnt_o[1]}, (n % 2 == 0) ? 32'b10 : 32'b01);
            if (n > 0) chk("tie_gnt_spacing", cyc - g_prev, 32'd4);
            g_prev = cyc;
            step();
            w = 0;
            while (!(c_ack_o[1] || l_ack_o[1]) && w < 12) begin step(); w++; end
            chk("tie_ack_latency", cyc - g_prev, 32'd2);
            if (n % 2 == 0) begin
                chk("tie_c_ack",   32'(c_ack_o[1]), 32'd1);
                chk("tie_c_rdata", c_rdata_o[1], 32'hDEADBEEF);
                chk("tie_l_rdata_kept", l_rdata_o[1], l_exp);
            end else begin
                chk("tie_l_ack",   32'(l_ack_o[1]), 32'd1);
                chk("tie_l_rdata", l_rdata_o[1], 32'h12345678);
                chk("tie_c_rdata_kept", c_rdata_o[1], 32'hDEADBEEF);
                l_exp = 32'h12345678;
            end
            $display("txn %0d tie read port %s c_rdata %h l_rdata %h",
                     n, (n % 2 == 0) ? "C" : "L", c_rdata_o[1], l_rdata_o[1]);
        end
        c_req = 0; l_req = 0;
        step(); step();

        // ---------------- single-port back-to-back writes ----------------
        c_req = 1; c_we = 1; c_addr = 8'h30; c_wdata = 32'hA5A5A5A5;
        w = 0;
        while (!(c_gnt_o[1] || l_gnt_o[1]) && w < 12) begin step(); w++; end
        chk("sp_gnt1", {c_gnt_o[1], l_gnt_o[1]}, 32'b10);
        g_prev = cyc;
        step();
        w = 0;
        while (!(c_gnt_o[1] || l_gnt_o[1]) && w < 12) begin step(); w++; end
        chk("sp_gnt2", {c_gnt_o[1], l_gnt_o[1]}, 32'b10);
        chk("sp_gap",  cyc - g_prev, 32'd3);
        c_req = 0;
        step();
        chk("sp_ack", 32'(c_ack_o[1]), 32'd1);
        step();
        $display("txn C write x2 addr 30 gap %0d", cyc - g_prev - 2);

        // ---------------- RD_LAT sweep ----------------
        rst = 1'b1;
        step();
        rst = 1'b0;
        c_req = 1; c_we = 1; c_addr = 8'hFF; c_wdata = 32'h00C0FFEE;
        step();
        chk("sw_wgnt", 32'(c_gnt_o), 32'hF);
        c_req = 0;
        step();
        chk("sw_wack", 32'(c_ack_o), 32'hF);
        step();
        c_req = 1; c_we = 0; c_addr = 8'hFF;
        step();
        chk("sw_rgnt", 32'(c_gnt_o), 32'hF);
        for (int k = 0; k < 4; k++) begin
            ack_at[k] = -1;
            chk("sw_addr", 32'(maddr_o[k]), 32'hFF);
        end
        c_req = 0;
        for (int s = 1; s <= 6; s++) begin
            step();
            for (int k = 0; k < 4; k++) if (c_ack_o[k] && ack_at[k] < 0) ack_at[k] = s;
        end
        for (int k = 0; k < 4; k++) begin
            chk("sw_ack_lat", ack_at[k], 32'(k + 1));
            chk("sw_rdata",   c_rdata_o[k], 32'h00C0FFEE);
            $display("txn sweep RD_LAT %0d read addr ff ack after %0d data %h",
                     k + 1, ack_at[k], c_rdata_o[k]);
        end

        // ---------------- reset during WAIT ----------------
        c_req = 1; c_we = 0; c_addr = 8'h10;
        step();
        chk("mr_gnt", 32'(c_gnt_o[1]), 32'd1);
        c_req = 0;
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("mr_busy_clr",  32'(busy_o[1]), 32'd0);
        chk("mr_rdata_clr", c_rdata_o[1], 32'd0);
        chk("mr_addr_clr",  32'(maddr_o[1]), 32'd0);
        ack_seen = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            ack_seen = ack_seen | c_ack_o[1] | wren_o[1];
        end
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            ack_seen = ack_seen | c_ack_o[1] | wren_o[1];
        end
        chk("mr_no_ack_wren", 32'(ack_seen), 32'd0);
        c_req = 1; c_we = 0; c_addr = 8'h10;
        step();
        chk("mr_post_gnt", 32'(c_gnt_o[1]), 32'd1);
        c_req = 0;
        step();
        step();
        chk("mr_post_ack",   32'(c_ack_o[1]), 32'd1);
        chk("mr_post_rdata", c_rdata_o[1], 32'hDEADBEEF);
        $display("txn C read after reset addr 10 data %h", c_rdata_o[1]);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
